// File: rtl/regs_wr_arbiter_pkg.sv
// Shared encodings for the register-bank write arbiter: bank control codes,
// load-unit width modes and grant identifiers.
package regs_pkg;

    localparam logic [2:0] CTL_FULL = 3'b000;
    localparam logic [2:0] CTL_LO   = 3'b001;
    localparam logic [2:0] CTL_HI   = 3'b010;
    localparam logic [2:0] CTL_PC   = 3'b011;
    localparam logic [2:0] CTL_IDLE = 3'b111;

    typedef enum logic [1:0] {
        MODE_FULL     = 2'b00,
        MODE_LO       = 2'b01,
        MODE_HI       = 2'b10,
        MODE_FULL_ALT = 2'b11
    } mem_mode_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_ALU  = 2'b01,
        GNT_MEM  = 2'b10,
        GNT_PC   = 2'b11
    } grant_e;

    function automatic logic [15:0] reg_onehot(input logic [3:0] idx);
        reg_onehot = 16'd1 << idx;
    endfunction

    // Mode 11 is not a real width; the bank sees it as a full write.
    function automatic logic [2:0] mode_to_ctl(input logic [1:0] mode);
        case (mode)
            MODE_LO: mode_to_ctl = CTL_LO;
            MODE_HI: mode_to_ctl = CTL_HI;
            default: mode_to_ctl = CTL_FULL;
        endcase
    endfunction

endpackage

// File: rtl/regs_wr_arbiter_rr_arbiter3.sv
// Round-robin pick among up to three requesters, with its own pointer that
// advances past the winner only when this arbiter issues a grant.
module rr_arbiter3 #(
    parameter int NUM_REQ = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] req,
    output logic [2:0] grant
);

    logic [1:0] ptr_q;
    logic [1:0] next_ptr;
    logic [1:0] idx;
    logic       any;

    // Scan from the preferred slot around the ring; first requester wins.
    always_comb begin
        grant    = 3'b000;
        next_ptr = ptr_q;
        idx      = 2'b00;
        any      = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = 2'((int'(ptr_q) + k) % NUM_REQ);
            if (en && !any && req[idx]) begin
                grant[idx] = 1'b1;
                any        = 1'b1;
                next_ptr   = (idx == 2'(NUM_REQ - 1)) ? 2'd0 : idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 2'd0;
        end else if (any) begin
            ptr_q <= next_ptr;
        end
    end

endmodule

// File: rtl/regs_wr_arbiter.sv
// Shares the register bank's single write port between ALU writeback, the
// load unit and PC-save, registering the winner into a one-cycle output stage.
module regs_wr_arbiter
    import regs_pkg::*;
#(
    parameter int PC_PRIO = 1,
    parameter int PC_REG  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [3:0]  alu_reg,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [3:0]  mem_reg,
    input  logic [1:0]  mem_mode,
    input  logic [31:0] mem_data,
    input  logic        pc_valid,
    output logic        pc_ready,
    input  logic [31:0] pc_value,
    output logic [3:0]  rb_inpC,
    output logic [31:0] rb_data,
    output logic [31:0] rb_pc,
    output logic [2:0]  rb_control,
    output logic [15:0] pend_mask,
    output logic [1:0]  last_grant
);

    localparam logic PRIO = (PC_PRIO != 0);

    logic       allow;
    logic       pc_pick;
    logic       rr_en;
    logic [2:0] rr_req;
    logic [2:0] rr_grant;

    // With priority on, PC bypasses the ring entirely so its grants never
    // disturb the ALU/load pointer; otherwise PC is the third ring slot.
    assign allow   = !freeze && !rst;
    assign pc_pick = PRIO && pc_valid && allow;
    assign rr_en   = allow && !pc_pick;
    assign rr_req  = {(!PRIO && pc_valid), mem_valid, alu_valid};

    rr_arbiter3 #(
        .NUM_REQ (PRIO ? 2 : 3)
    ) u_rr (
        .clk   (clk),
        .rst   (rst),
        .en    (rr_en),
        .req   (rr_req),
        .grant (rr_grant)
    );

    assign alu_ready = rr_grant[0];
    assign mem_ready = rr_grant[1];
    assign pc_ready  = pc_pick | rr_grant[2];

    // Output stage reloads every edge; a PC write leaves inpC/data untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_inpC    <= 4'd0;
            rb_data    <= 32'd0;
            rb_pc      <= 32'd0;
            rb_control <= CTL_IDLE;
            pend_mask  <= 16'd0;
            last_grant <= GNT_NONE;
        end else begin
            rb_control <= CTL_IDLE;
            pend_mask  <= 16'd0;
            last_grant <= GNT_NONE;
            if (alu_ready) begin
                rb_inpC    <= alu_reg;
                rb_data    <= alu_data;
                rb_control <= CTL_FULL;
                pend_mask  <= reg_onehot(alu_reg);
                last_grant <= GNT_ALU;
            end else if (mem_ready) begin
                rb_inpC    <= mem_reg;
                rb_data    <= mem_data;
                rb_control <= mode_to_ctl(mem_mode);
                pend_mask  <= reg_onehot(mem_reg);
                last_grant <= GNT_MEM;
            end else if (pc_ready) begin
                rb_pc      <= pc_value;
                rb_control <= CTL_PC;
                pend_mask  <= reg_onehot(4'(PC_REG));
                last_grant <= GNT_PC;
            end
        end
    end

endmodule
